irrigation_controller: RTL and testbench
========================================

IRRIGATION_CONTROLLER -- requirements
Module: irrigation_controller

Interface
- REQ-001: Parameter MIN_ON_CYCLES, default 8, minimum cycles spent in DRIP or SPRINKLE before a dryness-driven exit.
- REQ-002: Parameter MAX_ON_CYCLES, default 64, maximum cycles in DRIP or SPRINKLE before a forced REST.
- REQ-003: Parameter REST_CYCLES, default 16, cycles spent in REST.
- REQ-004: Parameter COUNT_W, default 8, width of the cycle counter, which SHALL hold MAX_ON_CYCLES.
- REQ-005: Parameter DEBOUNCE_CYCLES, default 4, stable cycles required by the input filter; used only when the REQ-026 macro is defined.
- REQ-006: The block SHALL have one clock; reset is asynchronous and active-high.
- REQ-007: Port clock, input, 1, system clock.
- REQ-008: Port reset, input, 1, asynchronous active-high reset.
- REQ-009: Ports soil_dry, soil_very_dry, tank_empty, input, 1 each; humidity and water-level sensor levels.
- REQ-010: Ports irrigation_on, splinker_on, dripper_on, output, 1 each; registered drive to the irrigation encoder.
- REQ-011: Port alarm_on, output, 1, registered low-water alarm.

Function
- REQ-012: FSM states SHALL be IDLE, DRIP, SPRINKLE, REST and ALARM; all outputs decode from the registered state only.
- REQ-013: Output decode SHALL be:
  - IDLE/REST: all 0.
  - DRIP: irrigation_on=1, dripper_on=1, splinker_on=0.
  - SPRINKLE: irrigation_on=1, splinker_on=1, dripper_on=0.
  - ALARM: alarm_on=1, all others 0.
- REQ-014: splinker_on and dripper_on SHALL never be 1 in the same cycle.
- REQ-015: tank_empty=1 SHALL force ALARM from any state, overriding every other condition.
- REQ-016: In ALARM with tank_empty=0, the FSM SHALL go to IDLE.
- REQ-017: In IDLE, soil_very_dry=1 SHALL go to SPRINKLE; else soil_dry=1 SHALL go to DRIP; else the FSM SHALL stay in IDLE.
- REQ-018: soil_very_dry=1 with soil_dry=0 SHALL be treated as very dry.
- REQ-019: In DRIP, soil_very_dry=1 SHALL go to SPRINKLE immediately, with no MIN_ON_CYCLES wait.
- REQ-020: In DRIP, soil_dry=0 and soil_very_dry=0 with counter >= MIN_ON_CYCLES SHALL go to IDLE.
- REQ-021: In SPRINKLE, soil_very_dry=0 with counter >= MIN_ON_CYCLES SHALL go to DRIP if soil_dry=1, else to IDLE.
- REQ-022: In DRIP or SPRINKLE, counter = MAX_ON_CYCLES-1 without another exit SHALL go to REST; this timeout outranks REQ-019 through REQ-021 but not REQ-015.
- REQ-023: In REST, counter = REST_CYCLES-1 SHALL go to IDLE.
- REQ-024: The counter SHALL clear to 0 on every state change, increment otherwise, and saturate at all-ones.
- REQ-025: Latency from a sampled input change to the new output SHALL be exactly 1 clock without debounce.

Configuration
- REQ-026: Macro IRRIGATION_DEBOUNCE_EN.
  - Defined: each of the three sensor inputs SHALL pass through a filter that updates only after DEBOUNCE_CYCLES consecutive equal samples, adding DEBOUNCE_CYCLES+1 cycles of latency; the filter resets to 0.
  - Undefined: the inputs SHALL feed the FSM directly, with no filter logic.

Reset
- REQ-027: While reset=1, the FSM SHALL be in IDLE, the counter at 0, and all outputs at 0, asynchronously and regardless of clock.
- REQ-028: Reset asserted mid-DRIP/SPRINKLE/ALARM SHALL drop the outputs without waiting for a clock edge.
- REQ-029: The first evaluation after reset deassertion SHALL occur on the next rising clock edge.

Structure
- REQ-030: Package irrigation_pkg SHALL hold the state encodings (IDLE=0, DRIP=1, SPRINKLE=2, REST=3, ALARM=4; 3 bits) and the default timing constants.
- REQ-031: The debounce filter SHALL be a sub-module, input_debouncer, one instance per sensor, instantiated only under IRRIGATION_DEBOUNCE_EN.

Verification
- REQ-032: Bench SHALL cover reset, then soil_dry=1 -> next cycle irrigation_on=1, dripper_on=1, splinker_on=0.
- REQ-033: Bench SHALL cover DRIP, then soil_dry=0 at counter 3 -> DRIP held until counter 8, then IDLE with all outputs 0.
- REQ-034: Bench SHALL cover DRIP, then soil_very_dry=1 -> SPRINKLE next cycle; then tank_empty=1 -> alarm_on=1 and splinker_on=0 one cycle later; then tank_empty=0 -> IDLE.
- REQ-035: Bench SHALL cover soil_very_dry held high -> SPRINKLE for 64 cycles, REST for 16 cycles, then SPRINKLE again.
- REQ-036: Bench SHALL cover reset pulsed mid-SPRINKLE between clock edges -> all outputs 0 immediately.
- REQ-037: Bench SHALL cover, with IRRIGATION_DEBOUNCE_EN, a 2-cycle soil_dry glitch -> no output change; a 4-cycle-stable soil_dry -> DRIP.

Source files
------------

// File: rtl/irrigation_pkg.sv
// Shared state encodings and default timing constants for the irrigation controller.
package irrigation_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    DRIP     = 3'd1,
    SPRINKLE = 3'd2,
    REST     = 3'd3,
    ALARM    = 3'd4
  } state_t;

  localparam int unsigned DEF_MIN_ON_CYCLES   = 8;
  localparam int unsigned DEF_MAX_ON_CYCLES   = 64;
  localparam int unsigned DEF_REST_CYCLES     = 16;
  localparam int unsigned DEF_COUNT_W         = 8;
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 4;

endpackage

// File: rtl/input_debouncer.sv
// Level filter: the output follows the input only after STABLE_CYCLES consecutive
// samples that differ from the current output. Resets to 0.
module input_debouncer #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic i_level,
  output logic o_level
);

  localparam int unsigned CNT_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;

  logic             r_sample;
  logic             r_level;
  logic [CNT_W-1:0] r_count;

  // r_count tracks how many sampled values in a row disagree with r_level
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sample <= 1'b0;
      r_level  <= 1'b0;
      r_count  <= '0;
    end else begin
      r_sample <= i_level;
      if (r_sample == r_level) begin
        r_count <= '0;
      end else if (r_count == CNT_W'(STABLE_CYCLES - 1)) begin
        r_level <= r_sample;
        r_count <= '0;
      end else begin
        r_count <= r_count + CNT_W'(1);
      end
    end
  end

  assign o_level = r_level;

endmodule

// File: rtl/irrigation_controller.sv
// Soil-moisture driven drip/sprinkler controller with low-water alarm.
// Optional sensor debounce filters are enabled by defining IRRIGATION_DEBOUNCE_EN.
module irrigation_controller
  import irrigation_pkg::*;
#(
  parameter int unsigned MIN_ON_CYCLES   = DEF_MIN_ON_CYCLES,
  parameter int unsigned MAX_ON_CYCLES   = DEF_MAX_ON_CYCLES,
  parameter int unsigned REST_CYCLES     = DEF_REST_CYCLES,
  parameter int unsigned COUNT_W         = DEF_COUNT_W,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clock,
  input  logic reset,
  input  logic soil_dry,
  input  logic soil_very_dry,
  input  logic tank_empty,
  output logic irrigation_on,
  output logic splinker_on,
  output logic dripper_on,
  output logic alarm_on
);

  // Reject timing values the cycle counter cannot represent
  if ((MAX_ON_CYCLES >= 2**COUNT_W) || (MIN_ON_CYCLES >= 2**COUNT_W) ||
      (REST_CYCLES > 2**COUNT_W) || (MAX_ON_CYCLES == 0) || (REST_CYCLES == 0) ||
      (DEBOUNCE_CYCLES == 0)) begin : g_bad_cfg
    $error("irrigation_controller: invalid timing parameters");
  end

  logic               w_soil_dry;
  logic               w_soil_very_dry;
  logic               w_tank_empty;
  state_t             r_state;
  state_t             w_next_state;
  logic [COUNT_W-1:0] r_count;
  logic               w_on_time_met;
  logic               w_on_timeout;
  logic               w_rest_done;

`ifdef IRRIGATION_DEBOUNCE_EN
  input_debouncer #(.STABLE_CYCLES(DEBOUNCE_CYCLES)) u_db_dry (
    .clock   (clock),
    .reset   (reset),
    .i_level (soil_dry),
    .o_level (w_soil_dry)
  );

  input_debouncer #(.STABLE_CYCLES(DEBOUNCE_CYCLES)) u_db_very_dry (
    .clock   (clock),
    .reset   (reset),
    .i_level (soil_very_dry),
    .o_level (w_soil_very_dry)
  );

  input_debouncer #(.STABLE_CYCLES(DEBOUNCE_CYCLES)) u_db_tank (
    .clock   (clock),
    .reset   (reset),
    .i_level (tank_empty),
    .o_level (w_tank_empty)
  );
`else
  assign w_soil_dry      = soil_dry;
  assign w_soil_very_dry = soil_very_dry;
  assign w_tank_empty    = tank_empty;
`endif

  assign w_on_time_met = (r_count >= COUNT_W'(MIN_ON_CYCLES));
  assign w_on_timeout  = (r_count == COUNT_W'(MAX_ON_CYCLES - 1));
  assign w_rest_done   = (r_count == COUNT_W'(REST_CYCLES - 1));

  // Next state; low water wins over everything, on-time limit wins over moisture exits
  always_comb begin
    w_next_state = r_state;
    if (w_tank_empty) begin
      w_next_state = ALARM;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_soil_very_dry) begin
            w_next_state = SPRINKLE;
          end else if (w_soil_dry) begin
            w_next_state = DRIP;
          end
        end
        DRIP: begin
          if (w_on_timeout) begin
            w_next_state = REST;
          end else if (w_soil_very_dry) begin
            w_next_state = SPRINKLE;
          end else if (!w_soil_dry && w_on_time_met) begin
            w_next_state = IDLE;
          end
        end
        SPRINKLE: begin
          if (w_on_timeout) begin
            w_next_state = REST;
          end else if (!w_soil_very_dry && w_on_time_met) begin
            if (w_soil_dry) begin
              w_next_state = DRIP;
            end else begin
              w_next_state = IDLE;
            end
          end
        end
        REST: begin
          if (w_rest_done) begin
            w_next_state = IDLE;
          end
        end
        ALARM:   w_next_state = IDLE;
        default: w_next_state = IDLE;
      endcase
    end
  end

  // State, dwell counter and output flops; outputs mirror the decode of the new state
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state       <= IDLE;
      r_count       <= '0;
      irrigation_on <= 1'b0;
      splinker_on   <= 1'b0;
      dripper_on    <= 1'b0;
      alarm_on      <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_next_state != r_state) begin
        r_count <= '0;
      end else if (r_count != {COUNT_W{1'b1}}) begin
        r_count <= r_count + COUNT_W'(1);
      end
      irrigation_on <= (w_next_state == DRIP) || (w_next_state == SPRINKLE);
      splinker_on   <= (w_next_state == SPRINKLE);
      dripper_on    <= (w_next_state == DRIP);
      alarm_on      <= (w_next_state == ALARM);
    end
  end

endmodule

// File: tb/tb_irrigation_controller.sv
// Self-checking bench for irrigation_controller: vector table, directed corner
// sequences and a randomized run against a behavioural model.
module tb_irrigation_controller;

  localparam int unsigned MIN_ON = 8;
  localparam int unsigned MAX_ON = 64;
  localparam int unsigned REST_N = 16;
  localparam int unsigned DEB    = 4;

  localparam int M_IDLE = 0;
  localparam int M_DRIP = 1;
  localparam int M_SPRK = 2;
  localparam int M_REST = 3;
  localparam int M_ALRM = 4;

  // Output patterns as {irrigation_on, splinker_on, dripper_on, alarm_on}
  localparam logic [3:0] O_OFF  = 4'b0000;
  localparam logic [3:0] O_DRIP = 4'b1010;
  localparam logic [3:0] O_SPRK = 4'b1100;
  localparam logic [3:0] O_ALRM = 4'b0001;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic soil_dry = 1'b0;
  logic soil_very_dry = 1'b0;
  logic tank_empty = 1'b0;
  logic irrigation_on, splinker_on, dripper_on, alarm_on;
  logic [3:0] w_obs;

  int total = 0;
  int bad   = 0;
  int m_mode = M_IDLE;
  int m_age  = 0;

  always #5 clock = ~clock;

  irrigation_controller #(
    .MIN_ON_CYCLES   (MIN_ON),
    .MAX_ON_CYCLES   (MAX_ON),
    .REST_CYCLES     (REST_N),
    .COUNT_W         (8),
    .DEBOUNCE_CYCLES (DEB)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .soil_dry      (soil_dry),
    .soil_very_dry (soil_very_dry),
    .tank_empty    (tank_empty),
    .irrigation_on (irrigation_on),
    .splinker_on   (splinker_on),
    .dripper_on    (dripper_on),
    .alarm_on      (alarm_on)
  );

  assign w_obs = {irrigation_on, splinker_on, dripper_on, alarm_on};

  typedef struct {
    logic       dry;
    logic       vdry;
    logic       empty;
    logic [3:0] exp;
  } vec_t;

  task automatic check_o(input string name, input logic [3:0] exp);
    total++;
    if (w_obs !== exp) begin
      bad++;
      $display("FAIL %s: outputs=%b expected=%b at %0t", name, w_obs, exp, $time);
    end
  endtask

  task automatic check_n(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic d, input logic vd, input logic te);
    soil_dry      = d;
    soil_very_dry = vd;
    tank_empty    = te;
  endtask

  // Leaves the bench on a falling edge with reset released and the model in IDLE
  task automatic do_reset();
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset  = 1'b0;
    m_mode = M_IDLE;
    m_age  = 0;
  endtask

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  function automatic logic [3:0] expect_of(input int mode);
    case (mode)
      M_DRIP:  return O_DRIP;
      M_SPRK:  return O_SPRK;
      M_ALRM:  return O_ALRM;
      default: return O_OFF;
    endcase
  endfunction

  // One clock of the controller's rules, age = cycles already spent in the current mode
  task automatic model_step(input logic d, input logic vd, input logic te);
    int nxt;
    nxt = m_mode;
    if (te) nxt = M_ALRM;
    else if (m_mode == M_IDLE) nxt = vd ? M_SPRK : (d ? M_DRIP : M_IDLE);
    else if (m_mode == M_ALRM) nxt = M_IDLE;
    else if (m_mode == M_REST) nxt = (m_age + 1 >= int'(REST_N)) ? M_IDLE : M_REST;
    else if (m_age + 1 >= int'(MAX_ON)) nxt = M_REST;
    else if (m_mode == M_DRIP && vd) nxt = M_SPRK;
    else if (m_age >= int'(MIN_ON) && !vd) nxt = d ? M_DRIP : M_IDLE;
    if (m_mode == M_DRIP && nxt == M_DRIP && m_age >= int'(MIN_ON) && !d) nxt = M_IDLE;
    m_age  = (nxt == m_mode) ? m_age + 1 : 0;
    m_mode = nxt;
  endtask

  initial begin
    #1 reset = 1'b1;
    #1 check_o("reset_async", O_OFF);
    do_reset();
    check_o("reset_release", O_OFF);

`ifdef IRRIGATION_DEBOUNCE_EN
    begin : deb_tests
      int lat;
      drive(1'b1, 1'b0, 1'b0);
      repeat (2) @(posedge clock);
      @(negedge clock);
      drive(1'b0, 1'b0, 1'b0);
      for (int c = 0; c < 10; c++) begin
        step();
        check_o("glitch_ignored", O_OFF);
      end
      drive(1'b1, 1'b0, 1'b0);
      lat = -1;
      for (int c = 1; c <= 20 && lat < 0; c++) begin
        step();
        if (dripper_on) lat = c;
      end
      check_n("debounce_latency", lat, int'(DEB) + 2);
      check_o("debounced_drip", O_DRIP);
    end
`else
    begin : table_tests
      vec_t vecs[12];
      vecs[0]  = '{1'b0, 1'b0, 1'b0, O_OFF};
      vecs[1]  = '{1'b1, 1'b0, 1'b0, O_DRIP};
      vecs[2]  = '{1'b1, 1'b1, 1'b0, O_SPRK};
      vecs[3]  = '{1'b1, 1'b1, 1'b1, O_ALRM};
      vecs[4]  = '{1'b0, 1'b1, 1'b1, O_ALRM};
      vecs[5]  = '{1'b0, 1'b0, 1'b0, O_OFF};
      vecs[6]  = '{1'b0, 1'b1, 1'b0, O_SPRK};
      vecs[7]  = '{1'b1, 1'b0, 1'b0, O_SPRK};
      vecs[8]  = '{1'b1, 1'b0, 1'b1, O_ALRM};
      vecs[9]  = '{1'b1, 1'b0, 1'b0, O_OFF};
      vecs[10] = '{1'b1, 1'b0, 1'b0, O_DRIP};
      vecs[11] = '{1'b0, 1'b0, 1'b0, O_DRIP};
      do_reset();
      foreach (vecs[i]) begin
        drive(vecs[i].dry, vecs[i].vdry, vecs[i].empty);
        step();
        check_o($sformatf("vec%0d", i), vecs[i].exp);
      end
    end

    // Dryness clears at dwell 3; DRIP must persist until dwell MIN_ON
    do_reset();
    drive(1'b1, 1'b0, 1'b0);
    @(posedge clock);
    for (int k = 0; k <= int'(MIN_ON); k++) begin
      @(negedge clock);
      check_o($sformatf("drip_hold_k%0d", k), O_DRIP);
      if (k == 3) soil_dry = 1'b0;
      @(posedge clock);
    end
    @(negedge clock);
    check_o("drip_exit_idle", O_OFF);

    // DRIP -> SPRINKLE -> ALARM -> IDLE -> SPRINKLE
    do_reset();
    drive(1'b1, 1'b0, 1'b0);
    step();
    check_o("seq_drip", O_DRIP);
    drive(1'b1, 1'b1, 1'b0);
    step();
    check_o("seq_sprinkle", O_SPRK);
    drive(1'b1, 1'b1, 1'b1);
    step();
    check_o("seq_alarm", O_ALRM);
    drive(1'b1, 1'b1, 1'b0);
    step();
    check_o("seq_alarm_to_idle", O_OFF);
    step();
    check_o("seq_idle_to_sprinkle", O_SPRK);

    // Very dry held: max on-time, rest period (plus one IDLE cycle), then sprinkle again
    begin : timeout_test
      int n_spr, n_off;
      bit back;
      n_spr = 0;
      n_off = 0;
      back  = 1'b0;
      do_reset();
      drive(1'b0, 1'b1, 1'b0);
      for (int c = 0; c < 300 && !back; c++) begin
        step();
        if (w_obs == O_SPRK) begin
          if (n_off > 0) back = 1'b1;
          else n_spr++;
        end else if (w_obs == O_OFF) begin
          n_off++;
        end
      end
      check_n("sprinkle_run", n_spr, int'(MAX_ON));
      check_n("rest_plus_idle_run", n_off, int'(REST_N) + 1);
      check_n("sprinkle_resumed", int'(back), 1);
    end

    // Reset pulses between clock edges drop outputs immediately
    do_reset();
    drive(1'b0, 1'b1, 1'b0);
    step();
    check_o("pre_reset_sprinkle", O_SPRK);
    @(posedge clock);
    #2 reset = 1'b1;
    #1 check_o("reset_mid_sprinkle", O_OFF);
    #1 reset = 1'b0;
    step();
    check_o("post_reset_first_edge", O_SPRK);
    tank_empty = 1'b1;
    step();
    check_o("pre_reset_alarm", O_ALRM);
    #1 reset = 1'b1;
    #1 check_o("reset_mid_alarm", O_OFF);
    #1 reset = 1'b0;
    drive(1'b0, 1'b0, 1'b0);

    // Randomized run against the model, inputs held for random spans
    begin : random_test
      int hold;
      logic rd, rvd, rte;
      hold = 0;
      rd = 1'b0;
      rvd = 1'b0;
      rte = 1'b0;
      do_reset();
      for (int c = 0; c < 3000; c++) begin
        if (hold == 0) begin
          rte  = ($urandom_range(0, 31) == 0);
          rvd  = ($urandom_range(0, 4) == 0);
          rd   = 1'($urandom_range(0, 1));
          hold = $urandom_range(1, 40);
        end
        hold--;
        drive(rd, rvd, rte);
        @(posedge clock);
        model_step(rd, rvd, rte);
        @(negedge clock);
        check_o("random_vs_model", expect_of(m_mode));
        check_n("spr_drip_exclusive", int'(splinker_on & dripper_on), 0);
      end
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
